// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - pointer sizing and Gray-code helpers shared by the FIFO write and read sides.
package fifo_pkg;

  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // 32-bit helpers; callers zero-extend narrower pointers and take the low bits back.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = gray;
    for (int i = 1; i < 32; i++) bin = bin ^ (gray >> i);
    return bin;
  endfunction

endpackage

// File: rtl/fifo_wptr_full_if.sv
// rtl/fifo_wptr_full_if.sv - write-side FIFO pointer bus; o_almost_full exists only with FIFO_ALMOST_FULL_EN.
interface fifo_wptr_full_if #(
  parameter int ADDR_WIDTH = 4
);
  import fifo_pkg::*;

  localparam int PW = ptr_width(ADDR_WIDTH);

  logic                  i_w_inc;
  logic [PW-1:0]         i_rq2_wptr;
  logic                  o_w_en;
  logic [ADDR_WIDTH-1:0] o_w_addr;
  logic [PW-1:0]         o_wptr_gray;
  logic                  o_full;
`ifdef FIFO_ALMOST_FULL_EN
  logic                  o_almost_full;
`endif

  modport master (
    output i_w_inc, i_rq2_wptr,
`ifdef FIFO_ALMOST_FULL_EN
    input  o_almost_full,
`endif
    input  o_w_en, o_w_addr, o_wptr_gray, o_full
  );

  modport slave (
    input  i_w_inc, i_rq2_wptr,
`ifdef FIFO_ALMOST_FULL_EN
    output o_almost_full,
`endif
    output o_w_en, o_w_addr, o_wptr_gray, o_full
  );

endinterface

// File: rtl/fifo_bin2gray.sv
// rtl/fifo_bin2gray.sv - combinational binary to Gray conversion of a WIDTH-bit value.
module fifo_bin2gray #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/fifo_wptr_full.sv
// rtl/fifo_wptr_full.sv - async FIFO write pointer (binary + registered Gray) and registered full flag.
// Optional registered almost-full output enabled by FIFO_ALMOST_FULL_EN.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_MARGIN  = 2
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  fifo_wptr_full_if.slave                      bus
);

  localparam int PW = ptr_width(ADDR_WIDTH);

  logic [PW-1:0] wbin, wgray;
  logic [PW-1:0] wbin_next, wgray_next;
  logic [PW-1:0] full_cmp;
  logic          full_r;
  logic          w_accept;

  assign w_accept  = bus.i_w_inc & ~full_r;
  assign wbin_next = wbin + {{(PW-1){1'b0}}, w_accept};

  fifo_bin2gray #(.WIDTH(PW)) u_bin2gray (
    .bin  (wbin_next),
    .gray (wgray_next)
  );

  // Full when the write pointer has lapped the read pointer: top two Gray bits inverted, rest equal.
  assign full_cmp = {~bus.i_rq2_wptr[PW-1:PW-2], bus.i_rq2_wptr[PW-3:0]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wbin   <= '0;
      wgray  <= '0;
      full_r <= 1'b0;
    end else begin
      wbin   <= wbin_next;
      wgray  <= wgray_next;
      full_r <= (wgray_next == full_cmp);
    end
  end

  assign bus.o_w_en      = w_accept;
  assign bus.o_w_addr    = wbin[ADDR_WIDTH-1:0];
  assign bus.o_wptr_gray = wgray;
  assign bus.o_full      = full_r;

`ifdef FIFO_ALMOST_FULL_EN
  localparam logic [PW-1:0] AF_THRESH = PW'(fifo_depth(ADDR_WIDTH) - AF_MARGIN);

  logic [PW-1:0] rbin;
  logic [PW-1:0] fill_next;
  logic          almost_full_r;

  always_comb begin
    rbin = '0;
    for (int i = 0; i < PW; i++) rbin[i] = ^(bus.i_rq2_wptr >> i);
  end

  assign fill_next = wbin_next - rbin;

  always_ff @(posedge i_clk) begin
    if (i_rst) almost_full_r <= 1'b0;
    else       almost_full_r <= (fill_next >= AF_THRESH);
  end

  assign bus.o_almost_full = almost_full_r;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb/tb_fifo_wptr_full.sv - directed bench for fifo_wptr_full (almost-full steps with FIFO_ALMOST_FULL_EN).
module tb_fifo_wptr_full;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic saw_full;

  always #5 clk = ~clk;

  fifo_wptr_full_if #(.ADDR_WIDTH(4)) bus ();

  fifo_wptr_full #(.ADDR_WIDTH(4), .AF_MARGIN(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_w_inc = 1'b0;
    bus.i_rq2_wptr = '0;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [4:0] g5(input int n);
    logic [4:0] b;
    b = 5'(n);
    return b ^ (b >> 1);
  endfunction

  initial begin
    rst = 1'b1;
    bus.i_w_inc = 1'b0;
    bus.i_rq2_wptr = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_full", bus.o_full, 0);
    chk("reset_gray", bus.o_wptr_gray, 0);
    chk("reset_addr", bus.o_w_addr, 0);
    chk("reset_wen", bus.o_w_en, 0);

    // Fill: 16 writes with the read pointer parked at 0
    bus.i_w_inc = 1'b1;
    #1;
    chk("first_wen", bus.o_w_en, 1);
    for (int i = 1; i <= 15; i++) tick();
    chk("full_after15", bus.o_full, 0);
    chk("addr_after15", bus.o_w_addr, 15);
    tick();
    chk("full_after16", bus.o_full, 1);
    chk("gray_after16", bus.o_wptr_gray, 5'b11000);
    chk("addr_after16", bus.o_w_addr, 0);

    // Writes while full are dropped
    for (int i = 0; i < 5; i++) begin
      chk("held_wen", bus.o_w_en, 0);
      tick();
    end
    chk("held_gray", bus.o_wptr_gray, 5'b11000);
    chk("held_addr", bus.o_w_addr, 0);
    chk("held_full", bus.o_full, 1);

    // Read pointer frees one slot without a write; full clears after one edge
    bus.i_w_inc = 1'b0;
    bus.i_rq2_wptr = 5'b00001;
    #1;
    chk("free_full_before", bus.o_full, 1);
    tick();
    chk("free_full_after", bus.o_full, 0);
    bus.i_w_inc = 1'b1;
    #1;
    chk("refill_wen", bus.o_w_en, 1);
    tick();
    bus.i_w_inc = 1'b0;
    chk("refill_full", bus.o_full, 1);
    chk("refill_gray", bus.o_wptr_gray, 5'b11001);
    chk("refill_addr", bus.o_w_addr, 1);

    // Freeing read change and a write in the same cycle: write dropped (full before edge), full clears
    bus.i_w_inc = 1'b1;
    bus.i_rq2_wptr = g5(2);
    tick();
    bus.i_w_inc = 1'b0;
    chk("same_cycle_full", bus.o_full, 0);
    chk("same_cycle_gray", bus.o_wptr_gray, 5'b11001);

    // 32 writes with the reader keeping pace: never full, pointer wraps to zero
    do_reset();
    saw_full = 1'b0;
    bus.i_w_inc = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.i_rq2_wptr = g5(i);
      tick();
      if (bus.o_full) saw_full = 1'b1;
      if (i == 15) chk("wrap_mid_gray", bus.o_wptr_gray, 5'b11000);
    end
    bus.i_w_inc = 1'b0;
    chk("wrap_never_full", saw_full, 0);
    chk("wrap_gray", bus.o_wptr_gray, 0);
    chk("wrap_addr", bus.o_w_addr, 0);

    // Reset concurrent with a write after 7 writes
    do_reset();
    bus.i_w_inc = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("seven_addr", bus.o_w_addr, 7);
    chk("seven_gray", bus.o_wptr_gray, 5'b00100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.i_w_inc = 1'b0;
    chk("rst_write_addr", bus.o_w_addr, 0);
    chk("rst_write_gray", bus.o_wptr_gray, 0);
    chk("rst_write_full", bus.o_full, 0);
    bus.i_w_inc = 1'b1;
    tick();
    bus.i_w_inc = 1'b0;
    chk("post_rst_addr", bus.o_w_addr, 1);
    chk("post_rst_gray", bus.o_wptr_gray, 5'b00001);

`ifdef FIFO_ALMOST_FULL_EN
    do_reset();
    chk("af_reset", bus.o_almost_full, 0);
    bus.i_w_inc = 1'b1;
    for (int i = 0; i < 13; i++) tick();
    chk("af_after13", bus.o_almost_full, 0);
    tick();
    chk("af_after14", bus.o_almost_full, 1);
    chk("af_full_after14", bus.o_full, 0);
    tick();
    tick();
    bus.i_w_inc = 1'b0;
    chk("af_full_after16", bus.o_full, 1);
    chk("af_still_after16", bus.o_almost_full, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
